// File: rtl/dbg_mem_arbiter.sv
// dbg_mem_arbiter: shares the program/data RAM between picorv32 and the debug loader.
// Optional DBG_LOCK_EN: debug is granted only while the CPU is held in reset.
module dbg_mem_arbiter #(
  parameter logic [31:0] MEM_BASE = 32'h00020000,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  input  logic              dbg_mem_op,
  input  logic [31:0]       dbg_adr,
  input  logic [31:0]       dbg_do,
  input  logic [3:0]        dbg_wren,
  output logic [31:0]       dbg_di,
  output logic              dbg_ack,
  input  logic              cpu_n_reset,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [3:0]        ram_wren,
  output logic [31:0]       ram_do,
  input  logic [31:0]       ram_di
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CPU_ACC,
    S_DBG_ACC
  } state_t;

  // RAM window size in bytes
  localparam logic [31:0] LP_SPAN = 32'd4 << ADDR_W;

  state_t r_state;
  state_t w_next;

  logic [31:0] w_cpu_off;
  logic [31:0] w_dbg_off;
  logic        w_cpu_hit;
  logic        w_dbg_hit;
  logic        w_dbg_gnt;

  logic              w_cpu_go;
  logic              w_dbg_go;
  logic              w_ram_en;
  logic [3:0]        w_ram_wren;
  logic [ADDR_W-1:0] w_ram_adr;
  logic [31:0]       w_ram_do;

  logic        r_cpu_rd;
  logic        r_dbg_ack;
  logic        r_dbg_hit;
  logic [31:0] r_dbg_di;
  logic [31:0] w_dbg_rd;

  assign w_cpu_off = mem_addr - MEM_BASE;
  assign w_dbg_off = dbg_adr - MEM_BASE;
  assign w_cpu_hit = w_cpu_off < LP_SPAN;
  assign w_dbg_hit = w_dbg_off < LP_SPAN;

`ifdef DBG_LOCK_EN
  // Debug may only touch memory while the CPU is parked in reset
  assign w_dbg_gnt = dbg_mem_op & ~cpu_n_reset;
`else
  logic w_unused_cpu_n_reset;
  assign w_unused_cpu_n_reset = cpu_n_reset;
  assign w_dbg_gnt = dbg_mem_op;
`endif

  // Next-state and RAM port steering; the CPU is served straight from IDLE
  always_comb begin
    w_next     = r_state;
    w_cpu_go   = 1'b0;
    w_dbg_go   = 1'b0;
    w_ram_en   = 1'b0;
    w_ram_wren = 4'h0;
    w_ram_adr  = w_cpu_off[ADDR_W+1:2];
    w_ram_do   = mem_wdata;
    unique case (r_state)
      S_IDLE: begin
        if (w_dbg_gnt) begin
          w_next = S_DBG_ACC;
        end else if (mem_valid) begin
          w_next   = S_CPU_ACC;
          w_cpu_go = 1'b1;
          w_ram_en = w_cpu_hit & n_reset;
          if (w_cpu_hit && n_reset) begin
            w_ram_wren = mem_wstrb;
          end
        end
      end
      S_CPU_ACC: begin
        w_next = w_dbg_gnt ? S_DBG_ACC : S_IDLE;
      end
      S_DBG_ACC: begin
        w_ram_adr = w_dbg_off[ADDR_W+1:2];
        w_ram_do  = dbg_do;
        if (w_dbg_gnt) begin
          w_dbg_go = 1'b1;
          w_ram_en = w_dbg_hit;
          if (w_dbg_hit) begin
            w_ram_wren = dbg_wren;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Remember what kind of access is completing next cycle
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cpu_rd  <= 1'b0;
      r_dbg_ack <= 1'b0;
      r_dbg_hit <= 1'b0;
    end else begin
      r_cpu_rd  <= w_cpu_go & w_cpu_hit & (mem_wstrb == 4'h0);
      r_dbg_ack <= w_dbg_go;
      r_dbg_hit <= w_dbg_go & w_dbg_hit;
    end
  end

  // Keep the last debug read word stable between acks
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_dbg_di <= 32'h0;
    end else if (r_dbg_ack) begin
      r_dbg_di <= w_dbg_rd;
    end
  end

  assign w_dbg_rd = r_dbg_hit ? ram_di : 32'h0;

  assign mem_ready = (r_state == S_CPU_ACC);
  assign mem_rdata = (mem_ready && r_cpu_rd) ? ram_di : 32'h0;
  assign dbg_ack   = r_dbg_ack;
  assign dbg_di    = r_dbg_ack ? w_dbg_rd : r_dbg_di;

  assign ram_en   = w_ram_en;
  assign ram_wren = w_ram_en ? w_ram_wren : 4'h0;
  assign ram_adr  = w_ram_adr;
  assign ram_do   = w_ram_do;

endmodule

// File: doc/dbg_mem_arbiter.md
Name: dbg_mem_arbiter

Overview:
Shares the single-port on-chip program/data RAM between the picorv32 native memory interface and the debug memory port used to load code while the CPU is held in reset. The debug port has fixed priority. Ownership changes only at access boundaries. The block sits between the CPU, the debug loader and the RAM inside the SoC top.

Parameters:
MEM_BASE, 32'h00020000, byte base address of the RAM window on both CPU and debug sides
ADDR_W, 10, RAM word-address width (RAM size = 2**ADDR_W words)

Ports:
clk  in  1  system clock
n_reset  in  1  asynchronous active-low reset
mem_valid  in  1  CPU access request (picorv32 native)
mem_addr  in  32  CPU byte address
mem_wdata  in  32  CPU write data
mem_wstrb  in  4  CPU byte write strobes (0 = read)
mem_ready  out  1  CPU access complete, one-cycle pulse
mem_rdata  out  32  CPU read data, valid with mem_ready
dbg_mem_op  in  1  debug owns memory while high (level)
dbg_adr  in  32  debug byte address
dbg_do  in  32  debug write data
dbg_wren  in  4  debug byte write enables (0 = read)
dbg_di  out  32  debug read data
dbg_ack  out  1  debug access completed in previous cycle
cpu_n_reset  in  1  CPU reset state (used only with DBG_LOCK_EN)
ram_en  out  1  RAM enable
ram_adr  out  ADDR_W  RAM word address
ram_wren  out  4  RAM byte write enables
ram_do  out  32  RAM write data
ram_di  in  32  RAM read data, 1-cycle synchronous latency

Behaviour:
- Reset (async, n_reset low): state IDLE; mem_ready, dbg_ack, ram_en, ram_wren = 0; mem_rdata, dbg_di = 0. Reset mid-access aborts it; no pending ready/ack is produced after release.
- Address map: hit = (addr - MEM_BASE) < 4*2**ADDR_W, unsigned 32-bit subtraction. Word address = (addr - MEM_BASE)[ADDR_W+1:2]. Byte offset bits are ignored.
- FSM states: IDLE, CPU_ACC, DBG_ACC.
- IDLE:
  - dbg_mem_op=1 has priority over mem_valid; go to DBG_ACC.
  - Otherwise mem_valid=1: drive RAM combinationally from the CPU this cycle (ram_en = hit, ram_wren = hit ? mem_wstrb : 0); go to CPU_ACC.
- CPU_ACC (one cycle):
  - mem_ready=1.
  - mem_rdata = ram_di on a hit read, 0 on a miss or a write.
  - Misses never hang: writes are dropped, ready is still given.
  - Next state: DBG_ACC if dbg_mem_op=1, else IDLE. Back-to-back CPU accesses therefore cost 2 cycles each.
  - A mem_valid seen in the same cycle as mem_ready is not a new request.
- DBG_ACC:
  - Each cycle with dbg_mem_op=1: ram_en = hit, ram_wren = hit ? dbg_wren : 0, ram_do = dbg_do.
  - dbg_ack registered high the following cycle; dbg_di = ram_di (0 on a miss), updated with dbg_ack.
  - Repeated cycles at the same address/data are idempotent.
  - dbg_mem_op=0: RAM idle this cycle; go to IDLE. dbg_ack for the last access still pulses.
- CPU requests in DBG_ACC wait; mem_ready stays 0 (no loss).
- mem_ready and dbg_ack are never high in the same cycle for accesses started in the same cycle.
- ram_wren is 0 whenever ram_en=0. No write ever occurs in the cycle of a state change out of CPU_ACC.

Optional Feature:
DBG_LOCK_EN
- Defined: debug access is granted only while cpu_n_reset=0.
  - dbg_mem_op with cpu_n_reset=1 is ignored: no RAM activity, dbg_ack stays 0.
  - If cpu_n_reset rises while in DBG_ACC, the state returns to IDLE next cycle and no further debug writes are made.
- Not defined: cpu_n_reset is unused; debug priority is unconditional.

Test Plan:
- Debug load: cpu_n_reset=0, dbg_mem_op=1, dbg_wren=F.
  - Stimulus: write 0x20000 <- fe010113, then 0x20004 <- 00012e23.
  - Required response: ram_adr 0 then 1, matching ram_do, dbg_ack one cycle after each.
- CPU read: mem_valid, mem_addr=0x20004, wstrb=0.
  - Required response: ram_en same cycle with ram_adr=1; mem_ready next cycle with mem_rdata=00012e23; next request accepted the cycle after.
- Collision: mem_valid and dbg_mem_op rise together in IDLE.
  - Required response: debug served first; CPU mem_ready only after dbg_mem_op falls (2 cycles later); no data corruption.
- Miss: CPU write 0x10000 with wstrb=F.
  - Required response: ram_wren stays 0; mem_ready 1 cycle later. CPU read 0x30000 returns 0.
- Reset mid-access: n_reset low during CPU_ACC.
  - Required response: mem_ready and ram_en immediately 0; after release, IDLE with no spurious mem_ready.
- With DBG_LOCK_EN: cpu_n_reset=1, dbg_mem_op=1, dbg_wren=F.
  - Required response: no ram_wren, no dbg_ack; CPU accesses are still served.
